// File: rtl/rd_circ_buf_ctrl_if.sv
// Bus bundle between the circular-buffer read controller, its requesting source and the memory datapath.
`default_nettype none
`ifndef MAC_INTERFACE_BYTES
`define MAC_INTERFACE_BYTES 32
`endif
`ifndef MAC_INTERFACE_BYTES_W
`define MAC_INTERFACE_BYTES_W 5
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

interface rd_circ_buf_ctrl_if #(
  parameter int BUF_PTR_W = 16,
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 16
);
  logic [ADDR_W-1:0]                  buf_base_addr;
  logic                               src_rd_buf_req_val;
  logic                               rd_buf_src_req_rdy;
  logic [BUF_PTR_W-1:0]               src_rd_buf_req_ptr;
  logic [LEN_W-1:0]                   src_rd_buf_req_len;
  logic                               ctrl_datapath_rd_req_val;
  logic                               datapath_ctrl_rd_req_rdy;
  logic [ADDR_W-1:0]                  ctrl_datapath_rd_req_addr;
  logic [LEN_W:0]                     ctrl_datapath_rd_req_size;
  logic                               datapath_ctrl_resp_data_val;
  logic                               ctrl_datapath_resp_data_rdy;
  logic                               datapath_ctrl_resp_data_last;
  logic                               write_upper;
  logic                               shift_upper;
  logic                               shift_lower;
  logic                               shift_lower_zeros;
  logic [`MAC_INTERFACE_BYTES_W-1:0]  mem_data_shift_bytes;
  logic                               rd_buf_src_resp_val;
  logic                               src_rd_buf_resp_rdy;
  logic                               rd_buf_src_resp_last;
  logic [`MAC_PADBYTES_W-1:0]         rd_buf_src_resp_padbytes;

  modport master (
    input  buf_base_addr, src_rd_buf_req_val, src_rd_buf_req_ptr, src_rd_buf_req_len,
           datapath_ctrl_rd_req_rdy, datapath_ctrl_resp_data_val, datapath_ctrl_resp_data_last,
           src_rd_buf_resp_rdy,
    output rd_buf_src_req_rdy, ctrl_datapath_rd_req_val, ctrl_datapath_rd_req_addr,
           ctrl_datapath_rd_req_size, ctrl_datapath_resp_data_rdy, write_upper, shift_upper,
           shift_lower, shift_lower_zeros, mem_data_shift_bytes, rd_buf_src_resp_val,
           rd_buf_src_resp_last, rd_buf_src_resp_padbytes
  );

  modport slave (
    output buf_base_addr, src_rd_buf_req_val, src_rd_buf_req_ptr, src_rd_buf_req_len,
           datapath_ctrl_rd_req_rdy, datapath_ctrl_resp_data_val, datapath_ctrl_resp_data_last,
           src_rd_buf_resp_rdy,
    input  rd_buf_src_req_rdy, ctrl_datapath_rd_req_val, ctrl_datapath_rd_req_addr,
           ctrl_datapath_rd_req_size, ctrl_datapath_resp_data_rdy, write_upper, shift_upper,
           shift_lower, shift_lower_zeros, mem_data_shift_bytes, rd_buf_src_resp_val,
           rd_buf_src_resp_last, rd_buf_src_resp_padbytes
  );
endinterface

`default_nettype wire

// File: rtl/rd_circ_buf_ctrl.sv
// Circular-buffer read controller: splits a (ptr,len) read into one or two line-aligned memory
// requests and sequences the datapath shift register to emit realigned output lines.
`default_nettype none
`ifndef MAC_INTERFACE_BYTES
`define MAC_INTERFACE_BYTES 32
`endif
`ifndef MAC_INTERFACE_BYTES_W
`define MAC_INTERFACE_BYTES_W 5
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module rd_circ_buf_ctrl #(
  parameter int BUF_PTR_W = 16,
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  rd_circ_buf_ctrl_if.master  bus
);
  localparam int B  = `MAC_INTERFACE_BYTES;
  localparam int LB = `MAC_INTERFACE_BYTES_W;
  localparam int PW = `MAC_PADBYTES_W;
  // Wide enough for ptr+len and s+len+B-1 without truncation.
  localparam int EW = ((LEN_W > BUF_PTR_W + 1) ? LEN_W : BUF_PTR_W + 1) + 1;
  localparam logic [EW-1:0] BUF_SIZE = EW'(1) << BUF_PTR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    REQ1  = 3'd2,
    PRIME = 3'd3,
    LOAD  = 3'd4,
    ZFILL = 3'd5,
    OUT   = 3'd6
  } state_t;

  state_t               state, state_nxt;
  logic [BUF_PTR_W-1:0] r_ptr;
  logic [EW-1:0]        r_len;
  logic [LB-1:0]        r_s;
  logic [EW-1:0]        r_in_lines;
  logic [EW-1:0]        r_out_lines;
  logic                 r_wrap;
  logic [EW-1:0]        r_in_cnt;
  logic [EW-1:0]        r_out_cnt;

  logic [EW-1:0]        w_ptr_e;
  logic [EW-1:0]        w_len_e;
  logic [LB-1:0]        w_s;
  logic [EW-1:0]        w_in_lines;
  logic [EW-1:0]        w_out_lines;
  logic                 w_wrap;
  logic                 w_req_hs;
  logic [BUF_PTR_W-1:0] w_ptr_al;
  logic [EW-1:0]        w_size0;
  logic [EW-1:0]        w_size1;
  logic                 w_last;
  logic [LB-1:0]        w_pad_raw;
  logic                 unused_resp_last;

  assign w_ptr_e     = EW'(bus.src_rd_buf_req_ptr);
  assign w_len_e     = EW'(bus.src_rd_buf_req_len);
  assign w_s         = bus.src_rd_buf_req_ptr[LB-1:0];
  assign w_in_lines  = (EW'(w_s) + w_len_e + EW'(B - 1)) >> LB;
  assign w_out_lines = (w_len_e + EW'(B - 1)) >> LB;
  assign w_wrap      = (w_ptr_e + w_len_e) > BUF_SIZE;
  assign w_req_hs    = (state == IDLE) && bus.src_rd_buf_req_val && (w_len_e != '0);

  assign w_ptr_al  = {r_ptr[BUF_PTR_W-1:LB], {LB{1'b0}}};
  assign w_size0   = r_wrap ? (BUF_SIZE - EW'(w_ptr_al)) : (EW'(r_s) + r_len);
  assign w_size1   = EW'(r_ptr) + r_len - BUF_SIZE;
  assign w_last    = (state == OUT) && (r_out_cnt == r_out_lines - EW'(1));
  assign w_pad_raw = ~r_len[LB-1:0] + 1'b1;

  // Line framing comes from the counters; the datapath's own last flag is redundant here.
  assign unused_resp_last = bus.datapath_ctrl_resp_data_last;

  assign bus.write_upper          = 1'b0;
  assign bus.mem_data_shift_bytes = r_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_len       <= '0;
      r_s         <= '0;
      r_in_lines  <= '0;
      r_out_lines <= '0;
      r_wrap      <= 1'b0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (w_req_hs) begin
            r_ptr       <= bus.src_rd_buf_req_ptr;
            r_len       <= w_len_e;
            r_s         <= w_s;
            r_in_lines  <= w_in_lines;
            r_out_lines <= w_out_lines;
            r_wrap      <= w_wrap;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
          end
        end
        PRIME: begin
          if (bus.datapath_ctrl_resp_data_val) r_in_cnt <= EW'(1);
        end
        LOAD: begin
          if (bus.datapath_ctrl_resp_data_val) r_in_cnt <= r_in_cnt + EW'(1);
        end
        OUT: begin
          if (bus.src_rd_buf_resp_rdy) r_out_cnt <= r_out_cnt + EW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt                       = state;
    bus.rd_buf_src_req_rdy          = 1'b0;
    bus.ctrl_datapath_rd_req_val    = 1'b0;
    bus.ctrl_datapath_rd_req_addr   = '0;
    bus.ctrl_datapath_rd_req_size   = '0;
    bus.ctrl_datapath_resp_data_rdy = 1'b0;
    bus.shift_upper                 = 1'b0;
    bus.shift_lower                 = 1'b0;
    bus.shift_lower_zeros           = 1'b0;
    bus.rd_buf_src_resp_val         = 1'b0;
    bus.rd_buf_src_resp_last        = w_last;
    bus.rd_buf_src_resp_padbytes    = w_last ? PW'(w_pad_raw) : '0;
    case (state)
      IDLE: begin
        bus.rd_buf_src_req_rdy = 1'b1;
        if (w_req_hs) state_nxt = REQ0;
      end
      REQ0: begin
        bus.ctrl_datapath_rd_req_val  = 1'b1;
        bus.ctrl_datapath_rd_req_addr = bus.buf_base_addr + ADDR_W'(w_ptr_al);
        bus.ctrl_datapath_rd_req_size = w_size0[LEN_W:0];
        if (bus.datapath_ctrl_rd_req_rdy) state_nxt = r_wrap ? REQ1 : PRIME;
      end
      REQ1: begin
        bus.ctrl_datapath_rd_req_val  = 1'b1;
        bus.ctrl_datapath_rd_req_addr = bus.buf_base_addr;
        bus.ctrl_datapath_rd_req_size = w_size1[LEN_W:0];
        if (bus.datapath_ctrl_rd_req_rdy) state_nxt = PRIME;
      end
      PRIME: begin
        bus.ctrl_datapath_resp_data_rdy = 1'b1;
        if (bus.datapath_ctrl_resp_data_val) begin
          bus.shift_upper = 1'b1;
          bus.shift_lower = 1'b1;
          state_nxt       = (r_in_lines > EW'(1)) ? LOAD : ZFILL;
        end
      end
      LOAD: begin
        bus.ctrl_datapath_resp_data_rdy = 1'b1;
        if (bus.datapath_ctrl_resp_data_val) begin
          bus.shift_upper = 1'b1;
          bus.shift_lower = 1'b1;
          state_nxt       = OUT;
        end
      end
      ZFILL: begin
        bus.shift_upper       = 1'b1;
        bus.shift_lower_zeros = 1'b1;
        state_nxt             = OUT;
      end
      OUT: begin
        bus.rd_buf_src_resp_val = 1'b1;
        if (bus.src_rd_buf_resp_rdy) begin
          if (w_last) state_nxt = IDLE;
          else        state_nxt = (r_in_cnt < r_in_lines) ? LOAD : ZFILL;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

`default_nettype wire

// File: tb/tb_rd_circ_buf_ctrl.sv
// Directed testbench for rd_circ_buf_ctrl with a 256-byte buffer and 32-byte lines.
`default_nettype none

module tb_rd_circ_buf_ctrl;
  localparam int P  = 8;
  localparam int AW = 64;
  localparam int LW = 16;
  localparam logic [63:0] BASE = 64'h0000_0001_0000_0400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rd_circ_buf_ctrl_if #(.BUF_PTR_W(P), .ADDR_W(AW), .LEN_W(LW)) bus ();
  rd_circ_buf_ctrl #(.BUF_PTR_W(P), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic        clr_mon = 1'b0;
  int          n_req, n_reqval, n_lines, n_out, n_overlap, n_zfill;
  logic [63:0] m_addr [4];
  logic [16:0] m_size [4];
  logic        m_last [8];
  logic [4:0]  m_pad  [8];
  logic [4:0]  m_shift[8];

  // Observes mid-cycle; every handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (clr_mon) begin
      n_req <= 0; n_reqval <= 0; n_lines <= 0; n_out <= 0; n_overlap <= 0; n_zfill <= 0;
    end else begin
      if (bus.ctrl_datapath_rd_req_val && bus.datapath_ctrl_rd_req_rdy) begin
        if (n_req < 4) begin
          m_addr[n_req] <= bus.ctrl_datapath_rd_req_addr;
          m_size[n_req] <= bus.ctrl_datapath_rd_req_size;
        end
        n_req <= n_req + 1;
      end
      if (bus.ctrl_datapath_rd_req_val) n_reqval <= n_reqval + 1;
      if (bus.datapath_ctrl_resp_data_val && bus.ctrl_datapath_resp_data_rdy) n_lines <= n_lines + 1;
      if (bus.rd_buf_src_resp_val && bus.src_rd_buf_resp_rdy) begin
        if (n_out < 8) begin
          m_last[n_out]  <= bus.rd_buf_src_resp_last;
          m_pad[n_out]   <= bus.rd_buf_src_resp_padbytes;
          m_shift[n_out] <= bus.mem_data_shift_bytes;
        end
        n_out <= n_out + 1;
      end
      if ((bus.shift_lower && bus.shift_lower_zeros) || bus.write_upper) n_overlap <= n_overlap + 1;
      if (bus.shift_lower_zeros) n_zfill <= n_zfill + 1;
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1 clr_mon = 1'b1;
    @(negedge clk); #1 clr_mon = 1'b0;
  endtask

  task automatic send_req(input logic [P-1:0] p, input logic [LW-1:0] l);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.src_rd_buf_req_ptr = p;
    bus.src_rd_buf_req_len = l;
    bus.src_rd_buf_req_val = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rd_buf_src_req_rdy) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.src_rd_buf_req_val = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL req_accept: got rdy=0 want rdy=1 within 50 cycles"); end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.rd_buf_src_req_rdy) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    total++;
    if (!ok) begin bad++; $display("FAIL idle_timeout: got busy want idle within 300 cycles"); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.ctrl_datapath_rd_req_val, bus.rd_buf_src_resp_val, bus.ctrl_datapath_resp_data_rdy} !== 3'b000) begin
      bad++; $display("FAIL reset_vals: got %b want 000",
        {bus.ctrl_datapath_rd_req_val, bus.rd_buf_src_resp_val, bus.ctrl_datapath_resp_data_rdy});
    end
    total++;
    if ({bus.write_upper, bus.shift_upper, bus.shift_lower, bus.shift_lower_zeros} !== 4'b0000) begin
      bad++; $display("FAIL reset_shift_ctrl: got %b want 0000",
        {bus.write_upper, bus.shift_upper, bus.shift_lower, bus.shift_lower_zeros});
    end
    total++;
    if (bus.mem_data_shift_bytes !== 5'd0) begin
      bad++; $display("FAIL reset_shift_bytes: got %0d want 0", bus.mem_data_shift_bytes);
    end
    total++;
    if (bus.rd_buf_src_req_rdy !== 1'b1) begin
      bad++; $display("FAIL reset_idle_rdy: got %b want 1", bus.rd_buf_src_req_rdy);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_aligned();
    clear_mon();
    send_req(8'd0, 16'd64);
    wait_idle();
    total++; if (n_req !== 1) begin bad++; $display("FAIL al_nreq: got %0d want 1", n_req); end
    total++; if (m_addr[0] !== BASE) begin bad++; $display("FAIL al_addr: got %h want %h", m_addr[0], BASE); end
    total++; if (m_size[0] !== 17'd64) begin bad++; $display("FAIL al_size: got %0d want 64", m_size[0]); end
    total++; if (n_out !== 2) begin bad++; $display("FAIL al_nout: got %0d want 2", n_out); end
    total++; if ({m_last[1], m_last[0]} !== 2'b10) begin bad++; $display("FAIL al_last: got %b want 10", {m_last[1], m_last[0]}); end
    total++; if (m_pad[1] !== 5'd0) begin bad++; $display("FAIL al_pad: got %0d want 0", m_pad[1]); end
    total++; if (m_shift[1] !== 5'd0) begin bad++; $display("FAIL al_shift: got %0d want 0", m_shift[1]); end
    total++; if (n_lines !== 2) begin bad++; $display("FAIL al_lines: got %0d want 2", n_lines); end
    total++; if (n_overlap !== 0) begin bad++; $display("FAIL al_overlap: got %0d want 0", n_overlap); end
  endtask

  task automatic test_unaligned();
    clear_mon();
    send_req(8'd5, 16'd40);
    wait_idle();
    total++; if (n_req !== 1) begin bad++; $display("FAIL un_nreq: got %0d want 1", n_req); end
    total++; if (m_addr[0] !== BASE) begin bad++; $display("FAIL un_addr: got %h want %h", m_addr[0], BASE); end
    total++; if (m_size[0] !== 17'd45) begin bad++; $display("FAIL un_size: got %0d want 45", m_size[0]); end
    total++; if (n_out !== 2) begin bad++; $display("FAIL un_nout: got %0d want 2", n_out); end
    total++; if ({m_last[1], m_last[0]} !== 2'b10) begin bad++; $display("FAIL un_last: got %b want 10", {m_last[1], m_last[0]}); end
    total++; if ({m_pad[1], m_pad[0]} !== {5'd24, 5'd0}) begin bad++; $display("FAIL un_pad: got %0d,%0d want 0,24", m_pad[0], m_pad[1]); end
    total++; if (m_shift[0] !== 5'd5) begin bad++; $display("FAIL un_shift: got %0d want 5", m_shift[0]); end
    total++; if (n_lines !== 2) begin bad++; $display("FAIL un_lines: got %0d want 2", n_lines); end
    total++; if (n_zfill !== 1) begin bad++; $display("FAIL un_zfill: got %0d want 1", n_zfill); end
  endtask

  task automatic test_wrap();
    clear_mon();
    send_req(8'd240, 16'd40);
    wait_idle();
    total++; if (n_req !== 2) begin bad++; $display("FAIL wr_nreq: got %0d want 2", n_req); end
    total++; if (m_addr[0] !== BASE + 64'd224) begin bad++; $display("FAIL wr_addr0: got %h want %h", m_addr[0], BASE + 64'd224); end
    total++; if (m_size[0] !== 17'd32) begin bad++; $display("FAIL wr_size0: got %0d want 32", m_size[0]); end
    total++; if (m_addr[1] !== BASE) begin bad++; $display("FAIL wr_addr1: got %h want %h", m_addr[1], BASE); end
    total++; if (m_size[1] !== 17'd24) begin bad++; $display("FAIL wr_size1: got %0d want 24", m_size[1]); end
    total++; if (n_out !== 2) begin bad++; $display("FAIL wr_nout: got %0d want 2", n_out); end
    total++; if (m_pad[1] !== 5'd24) begin bad++; $display("FAIL wr_pad: got %0d want 24", m_pad[1]); end
    total++; if (m_shift[0] !== 5'd16) begin bad++; $display("FAIL wr_shift: got %0d want 16", m_shift[0]); end
    total++; if (n_lines !== 2) begin bad++; $display("FAIL wr_lines: got %0d want 2", n_lines); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    send_req(8'd12, 16'd0);
    total++;
    if (bus.rd_buf_src_req_rdy !== 1'b1) begin bad++; $display("FAIL zl_idle: got rdy=%b want 1", bus.rd_buf_src_req_rdy); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (n_reqval !== 0) begin bad++; $display("FAIL zl_reqval: got %0d want 0", n_reqval); end
    total++; if (n_out !== 0) begin bad++; $display("FAIL zl_nout: got %0d want 0", n_out); end
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    int lines0;
    bus.src_rd_buf_resp_rdy = 1'b0;
    clear_mon();
    send_req(8'd5, 16'd40);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rd_buf_src_resp_val) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL bp_val_seen: got val=0 want val=1 within 50 cycles"); end
    lines0 = n_lines;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({bus.rd_buf_src_resp_val, bus.rd_buf_src_resp_last, bus.shift_upper, bus.shift_lower,
           bus.shift_lower_zeros, bus.ctrl_datapath_resp_data_rdy} !== 6'b100000) begin
        bad++; $display("FAIL bp_hold: got %b want 100000 at cycle %0d",
          {bus.rd_buf_src_resp_val, bus.rd_buf_src_resp_last, bus.shift_upper, bus.shift_lower,
           bus.shift_lower_zeros, bus.ctrl_datapath_resp_data_rdy}, i);
      end
    end
    @(posedge clk); #1;
    total++; if (n_lines !== lines0) begin bad++; $display("FAIL bp_lines: got %0d want %0d", n_lines, lines0); end
    bus.src_rd_buf_resp_rdy = 1'b1;
    wait_idle();
    total++; if (n_out !== 2) begin bad++; $display("FAIL bp_nout: got %0d want 2", n_out); end
    total++; if (m_pad[1] !== 5'd24) begin bad++; $display("FAIL bp_pad: got %0d want 24", m_pad[1]); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    bus.datapath_ctrl_resp_data_val = 1'b0;
    clear_mon();
    send_req(8'd5, 16'd90);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ctrl_datapath_resp_data_rdy) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rm_prime: got rdy=0 want rdy=1 within 50 cycles"); end
    @(posedge clk); #1 bus.datapath_ctrl_resp_data_val = 1'b1;
    @(posedge clk); #1 bus.datapath_ctrl_resp_data_val = 1'b0;
    total++;
    if ({bus.ctrl_datapath_resp_data_rdy, bus.rd_buf_src_resp_val} !== 2'b10) begin
      bad++; $display("FAIL rm_in_load: got %b want 10", {bus.ctrl_datapath_resp_data_rdy, bus.rd_buf_src_resp_val});
    end
    rst = 1'b0;
    #1;
    total++;
    if ({bus.ctrl_datapath_rd_req_val, bus.ctrl_datapath_resp_data_rdy, bus.rd_buf_src_resp_val,
         bus.shift_upper, bus.shift_lower, bus.shift_lower_zeros, bus.rd_buf_src_resp_last} !== 7'd0) begin
      bad++; $display("FAIL rm_outs_zero: got %b want 0000000",
        {bus.ctrl_datapath_rd_req_val, bus.ctrl_datapath_resp_data_rdy, bus.rd_buf_src_resp_val,
         bus.shift_upper, bus.shift_lower, bus.shift_lower_zeros, bus.rd_buf_src_resp_last});
    end
    total++;
    if ({bus.rd_buf_src_req_rdy, bus.mem_data_shift_bytes} !== {1'b1, 5'd0}) begin
      bad++; $display("FAIL rm_idle: got rdy=%b shift=%0d want rdy=1 shift=0",
        bus.rd_buf_src_req_rdy, bus.mem_data_shift_bytes);
    end
    @(posedge clk); #2 rst = 1'b1;
    bus.datapath_ctrl_resp_data_val = 1'b1;
    clear_mon();
    send_req(8'd5, 16'd40);
    wait_idle();
    total++; if (n_req !== 1) begin bad++; $display("FAIL rm_nreq: got %0d want 1", n_req); end
    total++; if (m_size[0] !== 17'd45) begin bad++; $display("FAIL rm_size: got %0d want 45", m_size[0]); end
    total++; if (n_out !== 2) begin bad++; $display("FAIL rm_nout: got %0d want 2", n_out); end
    total++; if (m_pad[1] !== 5'd24) begin bad++; $display("FAIL rm_pad: got %0d want 24", m_pad[1]); end
  endtask

  initial begin
    bus.buf_base_addr                = BASE;
    bus.src_rd_buf_req_val           = 1'b0;
    bus.src_rd_buf_req_ptr           = '0;
    bus.src_rd_buf_req_len           = '0;
    bus.datapath_ctrl_rd_req_rdy     = 1'b1;
    bus.datapath_ctrl_resp_data_val  = 1'b1;
    bus.datapath_ctrl_resp_data_last = 1'b0;
    bus.src_rd_buf_resp_rdy          = 1'b1;
    test_reset();
    test_aligned();
    test_unaligned();
    test_wrap();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got running want finished by 500000");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
